// File: rtl/fir_tdm_mc.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_mc
//  Description : Time-multiplexed multi-channel FIR filter. A single
//                multiply-accumulate engine serves CHANNELS round-robin
//                interleaved sample streams. Coefficients are double-buffered:
//                writes go to the shadow bank, and a requested swap takes
//                effect only between sums so no result ever mixes banks.
//                Results are rounded (half up), shifted and saturated.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                data_vld_i/_rdy_o   - input sample handshake
//                data_i              - signed input sample
//                coe_wr_en_i/addr/data - shadow-bank coefficient write
//                coe_swap_i          - request active/shadow bank swap
//                coe_bank_o          - index of the active bank
//                data_vld_o          - one-cycle result strobe
//                data_o/data_ch_o    - result and its channel
//                data_ovf_o          - result was saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_mc #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int COE_WIDTH      = 16,
    parameter int COE_TAPS       = 20,
    parameter int CHANNELS       = 4,
    parameter int ACC_WIDTH      = 37,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int OUT_SHIFT      = 15,
    localparam int c_tap_w = $clog2(COE_TAPS),
    localparam int c_ch_w  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_vld_i,
    output logic                      data_rdy_o,
    input  logic [DATA_IN_WIDTH-1:0]  data_i,
    input  logic                      coe_wr_en_i,
    input  logic [c_tap_w-1:0]        coe_wr_addr_i,
    input  logic [COE_WIDTH-1:0]      coe_wr_data_i,
    input  logic                      coe_swap_i,
    output logic                      coe_bank_o,
    output logic                      data_vld_o,
    output logic [DATA_OUT_WIDTH-1:0] data_o,
    output logic [c_ch_w-1:0]         data_ch_o,
    output logic                      data_ovf_o
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mac  = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;

    localparam int c_prod_w = DATA_IN_WIDTH + COE_WIDTH;
    localparam int c_rnd_sh = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    // Rounding and clamp constants live one bit wider than the accumulator
    // so adding the half-LSB term can never wrap.
    localparam logic signed [ACC_WIDTH:0] c_round =
        (OUT_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << c_rnd_sh) : '0;
    localparam logic signed [ACC_WIDTH:0] c_out_max =
        {{(ACC_WIDTH+2-DATA_OUT_WIDTH){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_out_min =
        {{(ACC_WIDTH+2-DATA_OUT_WIDTH){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_nxt;
    logic [c_tap_w-1:0]              r_k;
    logic [c_ch_w-1:0]               r_ch_cnt;
    logic [c_ch_w-1:0]               r_cur_ch;
    logic [c_tap_w-1:0]              r_ptr [CHANNELS];
    logic signed [DATA_IN_WIDTH-1:0] r_dly [CHANNELS][COE_TAPS];
    logic signed [COE_WIDTH-1:0]     r_coe [2][COE_TAPS];
    logic                            r_bank;
    logic                            r_swap_pend;
    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic                            r_vld;
    logic                            r_ovf;
    logic [DATA_OUT_WIDTH-1:0]       r_out;
    logic [c_ch_w-1:0]               r_out_ch;

    logic                            w_accept;
    logic                            w_swap_exec;
    logic                            w_last_tap;
    logic                            w_addr_ok;
    logic [c_tap_w-1:0]              w_ptr_cur;
    logic [c_tap_w-1:0]              w_tap_idx;
    logic [c_tap_w-1:0]              w_ptr_nxt;
    logic [c_ch_w-1:0]               w_ch_nxt;
    logic signed [DATA_IN_WIDTH-1:0] w_x;
    logic signed [COE_WIDTH-1:0]     w_h;
    logic signed [c_prod_w-1:0]      w_prod;
    logic signed [ACC_WIDTH:0]       w_rnd;
    logic signed [ACC_WIDTH:0]       w_shf;
    logic [DATA_OUT_WIDTH-1:0]       w_sat;
    logic                            w_ovf;

    assign w_accept    = data_vld_i & data_rdy_o;
    assign w_swap_exec = (r_state == c_st_idle) & r_swap_pend;
    assign w_last_tap  = (r_k == c_tap_w'(COE_TAPS - 1));
    assign w_addr_ok   = (32'(coe_wr_addr_i) < COE_TAPS);
    assign w_ch_nxt    = (r_ch_cnt == c_ch_w'(CHANNELS - 1)) ? '0 : r_ch_cnt + c_ch_w'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept)   w_state_nxt = c_st_mac;
            c_st_mac:  if (w_last_tap) w_state_nxt = c_st_out;
            c_st_out:                  w_state_nxt = c_st_idle;
            default:                   w_state_nxt = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        data_rdy_o = (r_state == c_st_idle);
    end

    // Tap k reads the sample k steps older than the newest one, which sits
    // at ptr. The modular add of COE_TAPS handles the wrap for any depth.
    always_comb begin
        w_ptr_cur = r_ptr[r_cur_ch];
        if (w_ptr_cur >= r_k) begin
            w_tap_idx = w_ptr_cur - r_k;
        end else begin
            w_tap_idx = w_ptr_cur + c_tap_w'(COE_TAPS) - r_k;
        end
        w_ptr_nxt = (w_ptr_cur == c_tap_w'(COE_TAPS - 1)) ? '0 : w_ptr_cur + c_tap_w'(1);
    end

    assign w_x    = r_dly[r_cur_ch][w_tap_idx];
    assign w_h    = r_coe[r_bank][r_k];
    assign w_prod = c_prod_w'(w_x) * c_prod_w'(w_h);

    // Round half up, arithmetic shift, then clamp to the output range.
    always_comb begin
        w_rnd = $signed({r_acc[ACC_WIDTH-1], r_acc}) + c_round;
        w_shf = w_rnd >>> OUT_SHIFT;
        w_ovf = 1'b0;
        w_sat = w_shf[DATA_OUT_WIDTH-1:0];
        if (w_shf > c_out_max) begin
            w_sat = c_out_max[DATA_OUT_WIDTH-1:0];
            w_ovf = 1'b1;
        end else if (w_shf < c_out_min) begin
            w_sat = c_out_min[DATA_OUT_WIDTH-1:0];
            w_ovf = 1'b1;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_ch_cnt    <= '0;
            r_cur_ch    <= '0;
            r_acc       <= '0;
            r_bank      <= 1'b0;
            r_swap_pend <= 1'b0;
            r_vld       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out       <= '0;
            r_out_ch    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_ptr[c] <= '0;
                for (int t = 0; t < COE_TAPS; t++) begin
                    r_dly[c][t] <= '0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < COE_TAPS; t++) begin
                    r_coe[b][t] <= '0;
                end
            end
        end else begin
            r_vld <= 1'b0;

            // Uses the pre-swap bank index, so a write on the swap edge
            // lands in the bank that is about to become active.
            if (coe_wr_en_i && w_addr_ok) begin
                r_coe[~r_bank][coe_wr_addr_i] <= coe_wr_data_i;
            end

            // Swaps only happen between sums; extra requests while one is
            // pending collapse into that single swap.
            if (w_swap_exec) begin
                r_bank      <= ~r_bank;
                r_swap_pend <= 1'b0;
            end else if (coe_swap_i) begin
                r_swap_pend <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_dly[r_ch_cnt][r_ptr[r_ch_cnt]] <= data_i;
                        r_acc    <= '0;
                        r_k      <= '0;
                        r_cur_ch <= r_ch_cnt;
                        r_ch_cnt <= w_ch_nxt;
                    end
                end
                c_st_mac: begin
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                    r_k   <= r_k + c_tap_w'(1);
                end
                c_st_out: begin
                    r_out            <= w_sat;
                    r_ovf            <= w_ovf;
                    r_out_ch         <= r_cur_ch;
                    r_vld            <= 1'b1;
                    r_ptr[r_cur_ch]  <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign coe_bank_o = r_bank;
    assign data_vld_o = r_vld;
    assign data_o     = r_out;
    assign data_ch_o  = r_out_ch;
    assign data_ovf_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tdm_mc
//  Description : Self-checking bench for fir_tdm_mc. Two instances share all
//                inputs (OUT_SHIFT 0 and 15); a behavioural model keeps
//                per-channel sample histories and both coefficient banks and
//                predicts every output, cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tdm_mc;
    localparam int T  = 4;
    localparam int CH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_vld_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        coe_wr_en_i = 1'b0;
    logic [1:0]  coe_wr_addr_i = '0;
    logic [15:0] coe_wr_data_i = '0;
    logic        coe_swap_i = 1'b0;

    logic        rdy0, rdy1, bank0, bank1, vld0, vld1, ovf0, ovf1, ch0, ch1;
    logic [15:0] out0, out1;

    always #5 clk = ~clk;

    fir_tdm_mc #(.DATA_IN_WIDTH(16), .COE_WIDTH(16), .COE_TAPS(T), .CHANNELS(CH),
                 .ACC_WIDTH(37), .DATA_OUT_WIDTH(16), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_vld_i(data_vld_i), .data_rdy_o(rdy0),
        .data_i(data_i), .coe_wr_en_i(coe_wr_en_i), .coe_wr_addr_i(coe_wr_addr_i),
        .coe_wr_data_i(coe_wr_data_i), .coe_swap_i(coe_swap_i), .coe_bank_o(bank0),
        .data_vld_o(vld0), .data_o(out0), .data_ch_o(ch0), .data_ovf_o(ovf0));

    fir_tdm_mc #(.DATA_IN_WIDTH(16), .COE_WIDTH(16), .COE_TAPS(T), .CHANNELS(CH),
                 .ACC_WIDTH(37), .DATA_OUT_WIDTH(16), .OUT_SHIFT(15)) u_dut1 (
        .clk(clk), .rst(rst), .data_vld_i(data_vld_i), .data_rdy_o(rdy1),
        .data_i(data_i), .coe_wr_en_i(coe_wr_en_i), .coe_wr_addr_i(coe_wr_addr_i),
        .coe_wr_data_i(coe_wr_data_i), .coe_swap_i(coe_swap_i), .coe_bank_o(bank1),
        .data_vld_o(vld1), .data_o(out1), .data_ch_o(ch1), .data_ovf_o(ovf1));

    // ---------------- behavioural model ----------------
    longint m_h    [2][T];
    longint m_hist [CH][T];   // index 0 = newest sample of that channel
    int     m_bank, m_ch, m_busy, m_pch, m_accepts, m_acc_cyc;
    int     cyc = 0;
    bit     m_pend, m_idle, m_exec;
    longint m_acc;
    bit     e_vld;
    int     e_ch;
    longint e_out [2];
    bit     e_ovf [2];

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    longint q_out0[$], q_out1[$], q_ch[$], q_ovf0[$], q_ovf1[$], q_lat[$];
    int     n_vld = 0;
    int     n_toggle = 0;
    logic   prev_bank = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint qget(input longint q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    function automatic void round_sat(input longint acc, input int sh,
                                      output longint r, output bit ovf);
        longint t;
        t = acc;
        if (sh > 0) t = t + (longint'(1) <<< (sh - 1));
        t   = t >>> sh;
        r   = t;
        ovf = 1'b0;
        if (t > 32767) begin
            r = 32767; ovf = 1'b1;
        end else if (t < -32768) begin
            r = -32768; ovf = 1'b1;
        end
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 2; b++) for (int k = 0; k < T; k++) m_h[b][k] = 0;
        for (int c = 0; c < CH; c++) for (int k = 0; k < T; k++) m_hist[c][k] = 0;
        m_bank = 0; m_ch = 0; m_busy = 0; m_pend = 1'b0; m_pch = 0;
        e_vld = 1'b0; e_ch = 0;
        e_out[0] = 0; e_out[1] = 0; e_ovf[0] = 1'b0; e_ovf[1] = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_clear();
        end else begin
            m_idle = (m_busy == 0);
            m_exec = m_idle && m_pend;
            e_vld  = 1'b0;
            if (coe_wr_en_i) m_h[1 - m_bank][coe_wr_addr_i] = longint'($signed(coe_wr_data_i));
            if (m_exec) m_bank = 1 - m_bank;
            m_pend = m_exec ? 1'b0 : (m_pend | coe_swap_i);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    e_vld = 1'b1;
                    e_ch  = m_pch;
                    round_sat(m_acc, 0,  e_out[0], e_ovf[0]);
                    round_sat(m_acc, 15, e_out[1], e_ovf[1]);
                end
            end else if (data_vld_i) begin
                for (int k = T - 1; k > 0; k--) m_hist[m_ch][k] = m_hist[m_ch][k-1];
                m_hist[m_ch][0] = longint'($signed(data_i));
                m_acc = 0;
                for (int k = 0; k < T; k++) m_acc += m_h[m_bank][k] * m_hist[m_ch][k];
                m_pch     = m_ch;
                m_ch      = (m_ch + 1) % CH;
                m_busy    = T + 1;
                m_accepts++;
                m_acc_cyc = cyc;
            end
        end
    end

    // ---------------- compare / monitor ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("rdy0",  rdy0,  m_busy == 0);
            chk("rdy1",  rdy1,  m_busy == 0);
            chk("vld0",  vld0,  e_vld);
            chk("vld1",  vld1,  e_vld);
            chk("bank0", bank0, m_bank);
            chk("bank1", bank1, m_bank);
            chk("data0", $signed(out0), e_out[0]);
            chk("data1", $signed(out1), e_out[1]);
            chk("ovf0",  ovf0,  e_ovf[0]);
            chk("ovf1",  ovf1,  e_ovf[1]);
            chk("ch0",   ch0,   e_ch);
            chk("ch1",   ch1,   e_ch);
            if (vld0 === 1'b1) begin
                q_out0.push_back(longint'($signed(out0)));
                q_out1.push_back(longint'($signed(out1)));
                q_ovf0.push_back(longint'(ovf0));
                q_ovf1.push_back(longint'(ovf1));
                q_ch.push_back(longint'(ch0));
                q_lat.push_back(longint'(cyc - m_acc_cyc));
                n_vld++;
            end
            if (bank0 !== prev_bank) n_toggle++;
            prev_bank = bank0;
        end
    end

    // ---------------- stimulus helpers (called and returning at negedge) ----------------
    task automatic clear_logs();
        q_out0.delete(); q_out1.delete(); q_ch.delete();
        q_ovf0.delete(); q_ovf1.delete(); q_lat.delete();
    endtask

    task automatic wr(input int a, input int v);
        coe_wr_en_i   = 1'b1;
        coe_wr_addr_i = a[1:0];
        coe_wr_data_i = v[15:0];
        @(negedge clk);
        coe_wr_en_i   = 1'b0;
    endtask

    task automatic swap_pulse();
        coe_swap_i = 1'b1;
        @(negedge clk);
        coe_swap_i = 1'b0;
    endtask

    task automatic send(input int v);
        int n;
        data_vld_i = 1'b1;
        data_i     = v[15:0];
        n = 0;
        while (rdy0 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("send_rdy_timeout", rdy0, 1);
        @(negedge clk);
        data_vld_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int imp_exp [5] = '{1, 2, 3, 4, 0};
    int acc0, nv0, tog0;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("reset_rdy",  rdy0, 1);
        chk("reset_vld",  vld0, 0);
        chk("reset_data", $signed(out0), 0);
        chk("reset_bank", bank0, 0);
        @(negedge clk);
        rst = 1'b0;

        // impulse response on ch0, zeros on ch1
        clear_logs();
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        swap_pulse();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1 : 0);
            send(0);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("impulse_ch0", qget(q_out0, 2*i), imp_exp[i]);
            chk("impulse_ch1", qget(q_out0, 2*i + 1), 0);
        end
        chk("impulse_chan_a", qget(q_ch, 0), 0);
        chk("impulse_chan_b", qget(q_ch, 1), 1);
        chk("impulse_latency", qget(q_lat, 0), 5);

        // rounding and saturation
        do_reset();
        clear_logs();
        wr(0, 32767); wr(1, 32767);
        swap_pulse();
        @(negedge clk);
        repeat (4) send(32767);
        repeat (8) @(negedge clk);
        chk("round_first",     qget(q_out1, 0), 32766);
        chk("round_first_ovf", qget(q_ovf1, 0), 0);
        chk("sat_second",      qget(q_out1, 2), 32767);
        chk("sat_second_ovf",  qget(q_ovf1, 2), 1);
        chk("sat_noshift",     qget(q_out0, 0), 32767);
        chk("sat_noshift_ovf", qget(q_ovf0, 0), 1);
        do_reset();
        clear_logs();
        wr(0, -32768);
        swap_pulse();
        @(negedge clk);
        send(-32768);
        repeat (8) @(negedge clk);
        chk("neg_sat",     qget(q_out1, 0), 32767);
        chk("neg_sat_ovf", qget(q_ovf1, 0), 1);

        // swap requested mid-sum, twice
        do_reset();
        clear_logs();
        for (int k = 0; k < T; k++) wr(k, 1);
        swap_pulse();
        @(negedge clk);
        wr(0, 2); wr(1, 3);
        tog0 = n_toggle;
        data_vld_i = 1'b1;
        data_i     = 16'd10;
        @(negedge clk);
        data_vld_i = 1'b0;
        swap_pulse();
        @(negedge clk);
        swap_pulse();
        repeat (8) @(negedge clk);
        chk("midswap_old_bank", qget(q_out0, 0), 10);
        chk("midswap_one_toggle", n_toggle - tog0, 1);
        chk("midswap_bank", bank0, 0);
        send(5);
        send(7);
        repeat (8) @(negedge clk);
        chk("newbank_ch1", qget(q_out0, 1), 10);
        chk("newbank_ch0", qget(q_out0, 2), 44);

        // backpressure: valid held high for 60 cycles
        acc0 = m_accepts;
        nv0  = n_vld;
        data_vld_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (rdy0 === 1'b1) data_i = 16'($urandom_range(0, 200) - 100);
            @(negedge clk);
        end
        data_vld_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_accepts", m_accepts - acc0, 10);
        chk("bp_outputs", n_vld - nv0, 10);

        // reset at MAC k=2
        data_vld_i = 1'b1;
        data_i     = 16'd123;
        @(negedge clk);
        data_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        nv0 = n_vld;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_no_vld", n_vld - nv0, 0);
        chk("rstmid_bank",   bank0, 0);
        chk("rstmid_data",   $signed(out0), 0);
        chk("rstmid_rdy",    rdy0, 1);
        clear_logs();
        send(500);
        repeat (8) @(negedge clk);
        chk("rstmid_zero_coe", qget(q_out0, 0), 0);
        chk("rstmid_chan",     qget(q_ch, 0), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            data_vld_i = $urandom_range(0, 1) == 1;
            if (rdy0 === 1'b1)
                data_i = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
            coe_wr_en_i   = ($urandom_range(0, 5) == 0);
            coe_wr_addr_i = 2'($urandom_range(0, 3));
            coe_wr_data_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20) - 10);
            coe_swap_i    = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        rst = 1'b0; data_vld_i = 1'b0; coe_wr_en_i = 1'b0; coe_swap_i = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
